// File: rtl/clkdiv_reset_sequencer.sv
// clkdiv_reset_sequencer
//   Reset and phase sequencer for a divide-by-DIV clock divider on the hclkin
//   domain. It filters PLL lock, starts the divider, mirrors its phase, and
//   releases the CPU reset after SETTLE_PERIODS full divided periods.
//
// Ports
//   hclkin        in   fast clock, shared with the divider
//   resetn        in   asynchronous active-low reset
//   pll_lock      in   PLL lock, asynchronous, 2-flop synchronized here
//   sw_reset_req  in   single-cycle CPU-only reset request (honoured in RUN)
//   div_resetn    out  divider RESETN
//   cpu_resetn    out  divided-domain CPU reset (active low)
//   div_phase     out  divider phase mirror, 0..DIV-1
//   div_ce        out  one-cycle strobe at div_phase == DIV-1 while running
//   ready         out  high while in RUN
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_RESET     | held by resetn / internal reset, all outputs low
// S_WAIT_LOCK | divider held in reset, counting consecutive lock samples
// S_SETTLE    | divider running, CPU in reset, counting div_ce strobes
// S_RUN       | divider running, CPU released

module clkdiv_reset_sequencer #(
  parameter int DIV            = 8,
  parameter int LOCK_FILTER    = 16,
  parameter int SETTLE_PERIODS = 4
) (
  input  logic                   hclkin,
  input  logic                   resetn,
  input  logic                   pll_lock,
  input  logic                   sw_reset_req,
  output logic                   div_resetn,
  output logic                   cpu_resetn,
  output logic [$clog2(DIV)-1:0] div_phase,
  output logic                   div_ce,
  output logic                   ready
);

  localparam int PW = $clog2(DIV);
  localparam int LW = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam int SW = (SETTLE_PERIODS > 1) ? $clog2(SETTLE_PERIODS) : 1;

  localparam logic [PW-1:0] PH_LAST     = PW'(DIV - 1);
  localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_FILTER - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_PERIODS - 1);

  typedef enum logic [1:0] {
    S_RESET     = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_SETTLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  logic [1:0]    rst_sync_q;
  logic          rst_int_n;
  logic          lock_meta_q;
  logic          lock_sync_q;
  state_t        state_q;
  logic [LW-1:0] lock_cnt_q;
  logic [SW-1:0] settle_cnt_q;
  logic [PW-1:0] phase_q;
  logic          div_resetn_q;
  logic          cpu_resetn_q;
  logic          ready_q;
  logic          div_ce_w;

  // Reset release synchronizer: assert async, release after 2 edges.
  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // Lock synchronizer is held clear until the internal reset has released,
  // so lock is only seen after the reset synchronizer has finished.
  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else if (!rst_int_n) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_sync_q <= lock_meta_q;
    end
  end

  assign div_ce_w = div_resetn_q && (phase_q == PH_LAST);

  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_RESET;
      lock_cnt_q   <= '0;
      settle_cnt_q <= '0;
      phase_q      <= '0;
      div_resetn_q <= 1'b0;
      cpu_resetn_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      // Free-running phase mirror; state branches below override on start/loss.
      if (div_resetn_q) begin
        phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
      end

      case (state_q)
        S_RESET: begin
          if (rst_int_n) begin
            state_q <= S_WAIT_LOCK;
          end
        end

        S_WAIT_LOCK: begin
          if (!lock_sync_q) begin
            lock_cnt_q <= '0;
          end else if (lock_cnt_q == LOCK_LAST) begin
            // Counter never passes LOCK_LAST: we leave the state instead.
            div_resetn_q <= 1'b1;
            phase_q      <= '0;
            settle_cnt_q <= '0;
            lock_cnt_q   <= '0;
            state_q      <= S_SETTLE;
          end else begin
            lock_cnt_q <= lock_cnt_q + LW'(1);
          end
        end

        S_SETTLE: begin
          if (!lock_sync_q) begin
            div_resetn_q <= 1'b0;
            cpu_resetn_q <= 1'b0;
            ready_q      <= 1'b0;
            phase_q      <= '0;
            lock_cnt_q   <= '0;
            settle_cnt_q <= '0;
            state_q      <= S_WAIT_LOCK;
          end else if (div_ce_w) begin
            if (settle_cnt_q == SETTLE_LAST) begin
              cpu_resetn_q <= 1'b1;
              ready_q      <= 1'b1;
              state_q      <= S_RUN;
            end else begin
              settle_cnt_q <= settle_cnt_q + SW'(1);
            end
          end
        end

        S_RUN: begin
          // Lock loss outranks a simultaneous soft reset request.
          if (!lock_sync_q) begin
            div_resetn_q <= 1'b0;
            cpu_resetn_q <= 1'b0;
            ready_q      <= 1'b0;
            phase_q      <= '0;
            lock_cnt_q   <= '0;
            settle_cnt_q <= '0;
            state_q      <= S_WAIT_LOCK;
          end else if (sw_reset_req) begin
            cpu_resetn_q <= 1'b0;
            ready_q      <= 1'b0;
            settle_cnt_q <= '0;
            state_q      <= S_SETTLE;
          end
        end

        default: begin
          state_q <= S_RESET;
        end
      endcase
    end
  end

  assign div_resetn = div_resetn_q;
  assign cpu_resetn = cpu_resetn_q;
  assign div_phase  = phase_q;
  assign div_ce     = div_ce_w;
  assign ready      = ready_q;

endmodule
